// File: rtl/mult_pkg.sv
// Shared definitions for the iterative MUL unit:
// FSM state encoding and the step-counter width helper.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fa1.sv
// One-bit full adder cell.
// Ports: x, y, ci -> s (sum), co (carry out).
module fa1 (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/seq_mult_n_add_row.sv
// W-bit ripple adder row built from fa1 cells.
// Ports: x, y (W) -> sum (W), co (carry out of the top bit).
module add_row #(
    parameter int W = 10
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         co
);

    logic [W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa1 u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    assign co = c[W];

endmodule

// File: rtl/seq_mult_n.sv
// Iterative shift-add multiplier (MUL unit), one adder row reused W times,
// optional two's complement mode, valid/ready on both sides.
// Ports: clk, rst_n; in_valid/in_ready with a, b, is_signed;
//        out_valid/out_ready with pro (2W); busy high in RUN or DONE.
module seq_mult_n
    import mult_pkg::*;
#(
    parameter int W         = 10,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] pro,
    output logic           busy
);

    localparam int CW = clog2(W);

    state_t state, state_nx;

    // Upper half is the running partial sum, lower half the
    // not-yet-consumed multiplier bits. The spare top bit of the
    // nominal 2W+1 accumulator is always zero after a shift, so it
    // is not stored.
    logic [2*W-1:0] acc;
    logic [W-1:0]   mcand;
    logic           neg;
    logic [CW-1:0]  cnt;

    logic           sgn;
    logic [W-1:0]   a_op;
    logic [W-1:0]   b_op;
    logic           accept;
    logic           last;
    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic           co;
    logic [2*W-1:0] step;

    // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1),
    // which still fits as an unsigned W-bit number.
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    assign sgn    = is_signed & SIGNED_EN;
    assign a_op   = sgn ? mag(a) : a;
    assign b_op   = sgn ? mag(b) : b;
    assign accept = (state == S_IDLE) && in_valid;
    assign last   = (cnt == CW'(W - 1));
    assign addend = acc[0] ? mcand : '0;

    add_row #(.W(W)) u_row (
        .x   (acc[2*W-1:W]),
        .y   (addend),
        .sum (sum),
        .co  (co)
    );

    // Carry re-enters as the new top bit, so nothing is lost on the shift.
    assign step = {co, sum, acc[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = S_RUN;
            end
            S_RUN: begin
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                busy     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            cnt   <= '0;
            pro   <= '0;
        end else begin
            if (accept) begin
                // A zero operand gives a zero product: keep it positive.
                neg   <= sgn & (a[W-1] ^ b[W-1]) & (|a) & (|b);
                mcand <= a_op;
                acc   <= {{W{1'b0}}, b_op};
                cnt   <= '0;
            end else if (state == S_RUN) begin
                acc <= step;
                cnt <= cnt + CW'(1);
                if (last) begin
                    pro <= neg ? (~step + (2*W)'(1)) : step;
                end
            end
        end
    end

endmodule
